// File: rtl/dmem_wbuf_ctrl_pkg.sv
// Shared definitions for the data-memory write-buffer controller.
//   WORD_SIZE        global data word width (default DATA_W)
//   DATA_ADDR_WIDTH  global data word-address width (default ADDR_W)
//   wbuf_entry_t     write-buffer entry {valid, addr, data} at the default widths
//   stat_cnt_t       statistics counter type (used when DMEM_STATS_EN is defined)
package dmem_wbuf_ctrl_pkg;

  localparam int unsigned WORD_SIZE       = 32;
  localparam int unsigned DATA_ADDR_WIDTH = 10;

  typedef struct packed {
    logic                       valid;
    logic [DATA_ADDR_WIDTH-1:0] addr;
    logic [WORD_SIZE-1:0]       data;
  } wbuf_entry_t;

  // Statistics counters wrap modulo 2**32.
  typedef logic [31:0] stat_cnt_t;

endpackage

// File: rtl/dmem_sram_1p.sv
// Single-port synchronous SRAM array, one access per cycle.
//   clk    clock, all accesses on posedge
//   en     access enable
//   we     write enable (write when en & we, read when en & ~we)
//   addr   word address
//   wdata  write data
//   rdata  read data, registered; valid the cycle after a read access
// Contents are not reset.
module dmem_sram_1p #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_wbuf_ctrl.sv
// Data-memory responder with a committed-store write buffer.
// Stores queue in a circular FIFO and drain one per cycle into a single-port array; loads
// complete one cycle after acceptance, forwarding from the newest matching buffered store.
//   clk, nrst          clock, asynchronous active-low reset
//   rd_en/rd_addr      load request (only when rd_ready)
//   rd_ready           load can be accepted (low while the buffer is full)
//   rd_valid/rd_data   load result, one cycle after acceptance; rd_data holds otherwise
//   wr_en/wr_addr/wr_data  committed store (only when wr_ready)
//   wr_ready           buffer has a free entry
//   wb_empty           buffer empty
// Optional build macro DMEM_STATS_EN adds stat_fwd_hits, stat_full_cycles, stat_drains.
module dmem_wbuf_ctrl
  import dmem_wbuf_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = DATA_ADDR_WIDTH,
  parameter int unsigned DATA_W   = WORD_SIZE,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wb_empty
`ifdef DMEM_STATS_EN
  ,
  output stat_cnt_t         stat_fwd_hits,
  output stat_cnt_t         stat_full_cycles,
  output stat_cnt_t         stat_drains
`endif
);

  localparam int unsigned PtrW = $clog2(WB_DEPTH);
  localparam int unsigned CntW = $clog2(WB_DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            entry_q [WB_DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q, count_d;

  logic              full, empty;
  logic              ld_acc, wr_acc, drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  logic              rd_valid_q;
  logic              fwd_hit_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] hold_q;

  logic              sram_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata;

  // Flow control and array-port arbitration.
  always_comb begin
    full     = (count_q == CntW'(WB_DEPTH));
    empty    = (count_q == '0);
    wr_ready = ~full;
    rd_ready = ~full;
    wb_empty = empty;
    ld_acc   = rd_en & ~full;
    wr_acc   = wr_en & ~full;
    // A full buffer blocks loads, so this also covers the forced drain when full.
    drain    = ~empty & ~ld_acc;
    count_d  = count_q + CntW'(wr_acc) - CntW'(drain);
  end

  // Walk entries oldest to newest so the newest match overwrites older ones.
  always_comb begin
    logic [PtrW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (entry_q[idx].valid && (entry_q[idx].addr == rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_q[idx].data;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < WB_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      if (drain) begin
        entry_q[head_q].valid <= 1'b0;
        head_q                <= head_q + 1'b1;
      end
      // Head and tail differ whenever both fire, since the buffer is neither empty nor full.
      if (wr_acc) begin
        entry_q[tail_q] <= '{valid: 1'b1, addr: wr_addr, data: wr_data};
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Drain and load never share a cycle, so the port is steered by drain alone.
  always_comb begin
    sram_en   = drain | ld_acc;
    sram_addr = drain ? entry_q[head_q].addr : rd_addr;
  end

  dmem_sram_1p #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (drain),
    .addr (sram_addr),
    .wdata(entry_q[head_q].data),
    .rdata(sram_rdata)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_valid_q <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      hold_q     <= '0;
    end else begin
      rd_valid_q <= ld_acc;
      if (ld_acc) begin
        fwd_hit_q  <= fwd_hit;
        fwd_data_q <= fwd_data;
      end
      if (rd_valid_q) begin
        hold_q <= rd_data;
      end
    end
  end

  // rd_data is the array or forward result in the valid cycle, the last result otherwise.
  always_comb begin
    rd_valid = rd_valid_q;
    if (rd_valid_q) begin
      rd_data = fwd_hit_q ? fwd_data_q : sram_rdata;
    end else begin
      rd_data = hold_q;
    end
  end

`ifdef DMEM_STATS_EN
  stat_cnt_t fwd_hits_q, full_cycles_q, drains_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fwd_hits_q    <= '0;
      full_cycles_q <= '0;
      drains_q      <= '0;
    end else begin
      if (ld_acc && fwd_hit) fwd_hits_q <= fwd_hits_q + 1'b1;
      if (full)              full_cycles_q <= full_cycles_q + 1'b1;
      if (drain)             drains_q <= drains_q + 1'b1;
    end
  end

  always_comb begin
    stat_fwd_hits    = fwd_hits_q;
    stat_full_cycles = full_cycles_q;
    stat_drains      = drains_q;
  end
`endif

endmodule

// File: tb/tb_dmem_wbuf_ctrl.sv
module tb_dmem_wbuf_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk, nrst;
  logic          rd_en, rd_ready, rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en, wr_ready, wb_empty;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`ifdef DMEM_STATS_EN
  logic [31:0]   stat_fwd_hits, stat_full_cycles, stat_drains;
`endif

  dmem_wbuf_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .WB_DEPTH(D)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .wb_empty(wb_empty)
`ifdef DMEM_STATS_EN
    ,
    .stat_fwd_hits   (stat_fwd_hits),
    .stat_full_cycles(stat_full_cycles),
    .stat_drains     (stat_drains)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: pending stores in program order plus a word array.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          wq[$];
  logic [DW-1:0] mmem[1024];
  logic [DW-1:0] exq[$];
  logic [DW-1:0] last_data;
  int            n_pass, n_total;
  int unsigned   m_fwd_hits, m_full_cycles, m_drains;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
  endtask

  // One clock cycle of stimulus; requests are only raised when the model says ready.
  task automatic cyc(input bit want_rd, input logic [AW-1:0] ra, input bit want_wr,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int            n;
    bit            ld, st, hit;
    logic [DW-1:0] e;
    @(negedge clk);
    n = wq.size();
    check("wr_ready", {31'b0, wr_ready}, {31'b0, n != D});
    check("rd_ready", {31'b0, rd_ready}, {31'b0, n != D});
    check("wb_empty", {31'b0, wb_empty}, {31'b0, n == 0});
    ld = want_rd && (n != D);
    st = want_wr && (n != D);
    rd_en = ld; rd_addr = ra; wr_en = st; wr_addr = wa; wr_data = wd;
    if (ld) begin
      e = mmem[ra];
      hit = 0;
      foreach (wq[i]) if (wq[i].addr == ra) begin e = wq[i].data; hit = 1; end
      exq.push_back(e);
      if (hit) m_fwd_hits++;
    end
    if (n == D) m_full_cycles++;
    if (n != 0 && !ld) begin
      mmem[wq[0].addr] = wq[0].data;
      void'(wq.pop_front());
      m_drains++;
    end
    if (st) wq.push_back('{wa, wd});
  endtask

  task automatic idle();
    cyc(0, '0, 0, '0, '0);
  endtask

  task automatic drain_all();
    int budget = 20;
    while (wq.size() != 0 && budget > 0) begin idle(); budget--; end
    if (wq.size() != 0) check("drain_budget", 32'(wq.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 0; rd_en = 0; wr_en = 0;
    wq.delete();
    exq.delete();
    last_data = '0;
    m_fwd_hits = 0; m_full_cycles = 0; m_drains = 0;
    #1;
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_wb_empty", {31'b0, wb_empty}, 32'd1);
    check("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
    check("rst_rd_ready", {31'b0, rd_ready}, 32'd1);
    @(negedge clk);
    nrst = 1;
  endtask

  // Monitor: every accepted load must be answered exactly one cycle later.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exq.size() != 0) begin
        e = exq.pop_front();
        check("rd_valid", {31'b0, rd_valid}, 32'd1);
        check("rd_data", rd_data, e);
        last_data = e;
      end else begin
        check("rd_valid_idle", {31'b0, rd_valid}, 32'd0);
        check("rd_data_hold", rd_data, last_data);
      end
    end
  end

  initial begin
    clk = 0; nrst = 0; rd_en = 0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    n_pass = 0; n_total = 0; last_data = '0;
    m_fwd_hits = 0; m_full_cycles = 0; m_drains = 0;
    #3;
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_wb_empty", {31'b0, wb_empty}, 32'd1);
    check("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
    check("rst_rd_ready", {31'b0, rd_ready}, 32'd1);
    @(negedge clk);
    nrst = 1;

    // Give every address the bench touches a known value.
    for (int a = 0; a < 64; a++) cyc(0, '0, 1, AW'(a), $urandom);
    drain_all();

    // Drained store read back from the array.
    cyc(0, '0, 1, 10'h010, 32'hA5A5_A5A5);
    drain_all();
    cyc(1, 10'h010, 0, '0, '0);
    idle();

    // Newest of two buffered stores forwards; array matches after draining.
    cyc(1, 10'h005, 1, 10'h020, 32'h11);
    cyc(1, 10'h006, 1, 10'h020, 32'h22);
    cyc(1, 10'h020, 0, '0, '0);
    drain_all();
    cyc(1, 10'h020, 0, '0, '0);
    idle();

    // Same-cycle store and load: the load sees the old value.
    cyc(1, 10'h030, 1, 10'h030, 32'h33);
    cyc(1, 10'h030, 0, '0, '0);
    drain_all();

    // Fill the buffer with loads blocking drains; full forces one drain.
    for (int k = 0; k < 4; k++) cyc(1, AW'(k + 8), 1, AW'(k + 56), 32'hC0DE_0000 + k);
    cyc(1, 10'h009, 1, 10'h00A, 32'hDEAD);
    cyc(1, 10'h009, 0, '0, '0);
    drain_all();
    for (int k = 0; k < 4; k++) cyc(1, AW'(k + 56), 0, '0, '0);
    idle();

    // Reset with three stores buffered: they must be discarded.
    for (int k = 0; k < 3; k++) cyc(1, AW'(k + 20), 1, AW'(k + 1), 32'hBAD0_0000 + k);
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1, AW'(k + 1), 0, '0, '0);
    idle();

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      cyc($urandom_range(0, 9) < 6, AW'($urandom_range(0, 63)),
          $urandom_range(0, 9) < 5, AW'($urandom_range(0, 63)), $urandom);
    end
    drain_all();
    for (int a = 0; a < 64; a++) cyc(1, AW'(a), 0, '0, '0);
    idle();
    idle();

`ifdef DMEM_STATS_EN
    check("stat_fwd_hits", stat_fwd_hits, m_fwd_hits);
    check("stat_full_cycles", stat_full_cycles, m_full_cycles);
    check("stat_drains", stat_drains, m_drains);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
